mem_cmd_entry: RTL and testbench
================================

# mem_cmd_entry

Parametrised successor to the board-level memory I/O controller. It turns debounced push-button and slide-switch activity into complete memory commands: mode selection (clear/read/write), paged nibble entry of address and write data, and a valid/ready request to the memory controller. It waits for completion and pages read data back to the hex display. It sits between the board I/O (keys, switches, hex drivers) and the memory controller command port. All logic runs on one clock; switches and keys are sampled, never used as clocks.

## Interface
- ADDR_W, 25, memory address width (≥1)
- DATA_W, 16, memory data width (≥1)
- NSW, 4, nibble switches per page; page width PW = 4*NSW bits
- Derived: AP = ceil(ADDR_W/PW) address pages, DP = ceil(DATA_W/PW) data pages
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_mode  in  1  mode/abort button, active high, asynchronous to clk
- key_step  in  1  advance/confirm button, active high, asynchronous
- sw  in  NSW  nibble-increment switches, asynchronous
- mem_ready  in  1  controller accepts request this cycle
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  read data, valid with mem_done
- mem_req  out  1  request valid
- mem_op  out  2  00 clear, 01 read, 10 write
- mem_addr  out  ADDR_W  entered address
- mem_wdata  out  DATA_W  entered write data
- mode_out  out  2  selected mode, same encoding as mem_op
- stage_out  out  3  0 SEL, 1 ADDR, 2 DATA, 3 ISSUE, 4 WAIT, 5 SHOW
- page_out  out  4  current page index
- disp_data  out  PW  hex display value
- busy  out  1  high in ISSUE and WAIT
- op_done  out  1  one-cycle pulse on accepted mem_done

## Operation
- Inputs key_mode, key_step, sw[i] pass through a 2-flop synchroniser, then rising-edge detection. Each edge is one single-cycle event. Falling edges are ignored.
- SEL: a key_mode event cycles the mode CLEAR→WRITE→READ→CLEAR. A key_step event with WRITE/READ goes to ADDR page 0. A key_step event with CLEAR goes directly to ISSUE. If both events occur together, key_mode wins.
- ADDR: a sw[i] event increments nibble i of address page p, bits [p*PW+4i+3 : p*PW+4i]. The nibble wraps from max to 0, with no carry.
  - A nibble partly above ADDR_W wraps within its valid bits only. Example: bit 24 alone toggles 0↔1.
  - A nibble wholly above ADDR_W is ignored.
  - A key_step event advances the page. After page AP-1 the block goes to DATA page 0 (WRITE) or ISSUE (READ).
- DATA: the same nibble rules apply to mem_wdata over DP pages. After page DP-1 the block goes to ISSUE.
- In ADDR or DATA, a key_mode event aborts to SEL. Address and data are retained.
- Simultaneous sw events on several switches all apply in the same cycle.
- A sw event in the same cycle as a key_step event applies to the current page before the page advances.
- sw events outside ADDR/DATA are ignored.
- ISSUE: mem_req=1. mem_op, mem_addr and mem_wdata stay stable until the cycle where mem_req & mem_ready, then the block goes to WAIT. Keys and switches are ignored.
- WAIT: on mem_done, op_done pulses. READ captures mem_rdata and goes to SHOW page 0. CLEAR/WRITE go to SEL with the mode unchanged. Keys are ignored.
- SHOW: a key_step event advances the read-data page. After page DP-1 the block goes to SEL. A key_mode event goes to SEL immediately.
- Display:
  - SEL: 0.
  - ADDR, DATA and SHOW: the current page slice, zero-extended.
  - ISSUE and WAIT: address page 0.
- page_out: current page in ADDR/DATA/SHOW, 0 otherwise.

## Timing
- Reset values:
  - state SEL, mode CLEAR, page 0.
  - mem_addr, mem_wdata, captured read data and disp_data all 0.
  - mem_req, busy, op_done all 0.
  - mem_op and mode_out 00.
- Reset is asynchronous and may assert in any state, including ISSUE/WAIT. mem_req drops immediately; a pending command is discarded.
- Button/switch rising edge to registered effect: 3 clk cycles (2 synchroniser + 1 edge register). The edge must be stable ≥3 cycles.
- mem_req rises the cycle after the ISSUE transition.
- The handshake completes in the cycle mem_ready is sampled high. mem_ready while mem_req=0 is ignored.
- mem_done is counted only in WAIT, i.e. from the cycle after acceptance. mem_done in other states is ignored.
- op_done is high for exactly the cycle after the accepted mem_done, the same cycle the state leaves WAIT.

## Test plan
- Reset, then no stimulus: all outputs 0, stage_out=0, mode_out=00.
- Mode cycling: key_mode ×3 → mode_out 10, 01, 00. key_mode and key_step together in SEL → mode advances only.
- Write entry:
  - Sequence: WRITE, step; sw0 ×17, sw3 ×2; step; sw2 ×3; step; sw1 ×1; step.
  - Expect mem_addr=0x1002001 and mem_wdata=0x0010.
  - Bit 24 toggled 3× ends at 1. sw0 wraps 17 increments to 1.
- Handshake: hold mem_ready=0 for 5 cycles → mem_req and payload stable. Then mem_ready=1 → WAIT. mem_done → op_done one cycle, state SEL, mode_out=10.
- Read: READ, address 0x0000123, mem_rdata=0xBEEF with mem_done → SHOW, disp_data=0xBEEF. step → SEL.
- Abort and reset:
  - key_mode in ADDR page 1 → SEL with address retained.
  - rst_n low during WAIT → mem_req=0 and all outputs at reset values at once.
  - A later mem_done is ignored.

Source files
------------

// File: rtl/mem_cmd_entry.sv
// mem_cmd_entry: turns synchronised key/switch edges into paged
// memory commands with a valid/ready request and read-back display.
module mem_cmd_entry #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16,
   parameter int NSW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_mode,
   input  logic              key_step,
   input  logic [NSW-1:0]    sw,
   input  logic              mem_ready,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic [1:0]        mem_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mode_out,
   output logic [2:0]        stage_out,
   output logic [3:0]        page_out,
   output logic [4*NSW-1:0]  disp_data,
   output logic              busy,
   output logic              op_done
);

   localparam int PW  = 4 * NSW;
   localparam int AP  = (ADDR_W + PW - 1) / PW;
   localparam int DP  = (DATA_W + PW - 1) / PW;
   localparam int NIN = NSW + 2;

   localparam logic [1:0] M_CLR = 2'b00;
   localparam logic [1:0] M_RD  = 2'b01;
   localparam logic [1:0] M_WR  = 2'b10;

   typedef enum logic [2:0] {
      SEL   = 3'd0,
      ADDR  = 3'd1,
      DATA  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      SHOW  = 3'd5
   } stage_t;

   // Nibble increment that wraps within the bits below the field width
   function automatic logic [3:0] bump(input logic [3:0] v,
                                       input int base,
                                       input int w);
      logic [3:0] m;
      for (int k = 0; k < 4; k++) m[k] = (base + k) < w;
      return (v + 4'd1) & m;
   endfunction

   logic [NIN-1:0]    rawIn, s1, s2, s3, ev;
   logic              evMode, evStep;
   logic [NSW-1:0]    evSw;
   stage_t            stateQ, stateN;
   logic [3:0]        pageQ, pageN;
   logic [1:0]        modeQ;
   logic [ADDR_W-1:0] addrQ;
   logic [DATA_W-1:0] wdataQ, rdataQ;
   logic              opDoneQ;
   logic [AP*PW-1:0]  addrCur, addrNxt;
   logic [DP*PW-1:0]  dataCur, dataNxt, rdCur;

   assign rawIn  = {key_mode, key_step, sw};
   assign ev     = s2 & ~s3;
   assign evMode = ev[NSW+1];
   assign evStep = ev[NSW];
   assign evSw   = ev[NSW-1:0];

   // Two-flop synchroniser plus previous-value register for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= rawIn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // State and page register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= SEL;
         pageQ  <= '0;
      end else begin
         stateQ <= stateN;
         pageQ  <= pageN;
      end
   end

   // Next-state and page sequencing
   always_comb begin
      stateN = stateQ;
      pageN  = pageQ;
      unique case (stateQ)
         SEL: begin
            if (!evMode && evStep) begin
               pageN  = '0;
               stateN = (modeQ == M_CLR) ? ISSUE : ADDR;
            end
         end
         ADDR: begin
            if (evMode) begin
               stateN = SEL;
               pageN  = '0;
            end else if (evStep) begin
               if (pageQ == 4'(AP - 1)) begin
                  pageN  = '0;
                  stateN = (modeQ == M_WR) ? DATA : ISSUE;
               end else begin
                  pageN = pageQ + 4'd1;
               end
            end
         end
         DATA: begin
            if (evMode) begin
               stateN = SEL;
               pageN  = '0;
            end else if (evStep) begin
               if (pageQ == 4'(DP - 1)) begin
                  pageN  = '0;
                  stateN = ISSUE;
               end else begin
                  pageN = pageQ + 4'd1;
               end
            end
         end
         ISSUE: begin
            if (mem_ready) stateN = WAIT;
         end
         WAIT: begin
            if (mem_done) begin
               pageN  = '0;
               stateN = (modeQ == M_RD) ? SHOW : SEL;
            end
         end
         SHOW: begin
            if (evMode) begin
               stateN = SEL;
               pageN  = '0;
            end else if (evStep) begin
               if (pageQ == 4'(DP - 1)) begin
                  stateN = SEL;
                  pageN  = '0;
               end else begin
                  pageN = pageQ + 4'd1;
               end
            end
         end
         default: begin
            stateN = SEL;
            pageN  = '0;
         end
      endcase
   end

   // Page-padded views of the payload with switch increments applied
   always_comb begin
      addrCur = '0;
      addrCur[ADDR_W-1:0] = addrQ;
      dataCur = '0;
      dataCur[DATA_W-1:0] = wdataQ;
      rdCur = '0;
      rdCur[DATA_W-1:0] = rdataQ;
      addrNxt = addrCur;
      dataNxt = dataCur;
      for (int i = 0; i < NSW; i++) begin
         if (evSw[i] && stateQ == ADDR)
            addrNxt[int'(pageQ)*PW + 4*i +: 4] =
               bump(addrCur[int'(pageQ)*PW + 4*i +: 4],
                    int'(pageQ)*PW + 4*i, ADDR_W);
         if (evSw[i] && stateQ == DATA)
            dataNxt[int'(pageQ)*PW + 4*i +: 4] =
               bump(dataCur[int'(pageQ)*PW + 4*i +: 4],
                    int'(pageQ)*PW + 4*i, DATA_W);
      end
   end

   // Mode, payload, captured read data and completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modeQ   <= M_CLR;
         addrQ   <= '0;
         wdataQ  <= '0;
         rdataQ  <= '0;
         opDoneQ <= 1'b0;
      end else begin
         if (stateQ == SEL && evMode) begin
            unique case (modeQ)
               M_CLR:   modeQ <= M_WR;
               M_WR:    modeQ <= M_RD;
               default: modeQ <= M_CLR;
            endcase
         end
         if (stateQ == ADDR) addrQ <= addrNxt[ADDR_W-1:0];
         if (stateQ == DATA) wdataQ <= dataNxt[DATA_W-1:0];
         if (stateQ == WAIT && mem_done && modeQ == M_RD)
            rdataQ <= mem_rdata;
         opDoneQ <= (stateQ == WAIT) && mem_done;
      end
   end

   // Output decode from state and registers
   always_comb begin
      mem_req   = (stateQ == ISSUE);
      busy      = (stateQ == ISSUE) || (stateQ == WAIT);
      disp_data = '0;
      unique case (stateQ)
         ADDR:        disp_data = addrCur[int'(pageQ)*PW +: PW];
         DATA:        disp_data = dataCur[int'(pageQ)*PW +: PW];
         SHOW:        disp_data = rdCur[int'(pageQ)*PW +: PW];
         ISSUE, WAIT: disp_data = addrCur[PW-1:0];
         default:     disp_data = '0;
      endcase
   end

   assign mem_op    = modeQ;
   assign mode_out  = modeQ;
   assign mem_addr  = addrQ;
   assign mem_wdata = wdataQ;
   assign stage_out = stateQ;
   assign page_out  = pageQ;
   assign op_done   = opDoneQ;

endmodule

// File: tb/tb_mem_cmd_entry.sv
// tb_mem_cmd_entry: directed scenarios for mem_cmd_entry with
// hand-computed expectations.
module tb_mem_cmd_entry;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_mode = 1'b0;
   logic        key_step = 1'b0;
   logic [3:0]  sw = 4'd0;
   logic        mem_ready = 1'b0;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = 16'd0;
   logic        mem_req;
   logic [1:0]  mem_op;
   logic [24:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mode_out;
   logic [2:0]  stage_out;
   logic [3:0]  page_out;
   logic [15:0] disp_data;
   logic        busy;
   logic        op_done;

   int total = 0;
   int bad = 0;

   mem_cmd_entry dut (
      .clk(clk), .rst_n(rst_n),
      .key_mode(key_mode), .key_step(key_step), .sw(sw),
      .mem_ready(mem_ready), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mode_out(mode_out), .stage_out(stage_out),
      .page_out(page_out), .disp_data(disp_data),
      .busy(busy), .op_done(op_done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pressMode();
      key_mode = 1'b1; tick(4); key_mode = 1'b0; tick(4);
   endtask

   task automatic pressStep();
      key_step = 1'b1; tick(4); key_step = 1'b0; tick(4);
   endtask

   task automatic pressBoth();
      key_mode = 1'b1; key_step = 1'b1; tick(4);
      key_mode = 1'b0; key_step = 1'b0; tick(4);
   endtask

   task automatic pressSw(input logic [3:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         sw = m; tick(4); sw = 4'd0; tick(4);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
      total++; if (stage_out !== 3'd0) begin bad++; $display("FAIL rst_stage got=%0d want=0", stage_out); end
      total++; if (mode_out !== 2'b00) begin bad++; $display("FAIL rst_mode got=%b want=00", mode_out); end
      total++; if (mem_req !== 1'b0 || busy !== 1'b0 || op_done !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b want=000", mem_req, busy, op_done); end
      total++; if (mem_addr !== 25'd0 || mem_wdata !== 16'd0) begin bad++; $display("FAIL rst_payload got=%h/%h want=0/0", mem_addr, mem_wdata); end
      total++; if (disp_data !== 16'd0 || page_out !== 4'd0 || mem_op !== 2'b00) begin bad++; $display("FAIL rst_disp got=%h/%0d/%b want=0/0/00", disp_data, page_out, mem_op); end
   endtask

   task automatic test_mode_cycle();
      pressMode();
      total++; if (mode_out !== 2'b10) begin bad++; $display("FAIL mode1 got=%b want=10", mode_out); end
      pressMode();
      total++; if (mode_out !== 2'b01) begin bad++; $display("FAIL mode2 got=%b want=01", mode_out); end
      pressMode();
      total++; if (mode_out !== 2'b00) begin bad++; $display("FAIL mode3 got=%b want=00", mode_out); end
      pressBoth();
      total++; if (mode_out !== 2'b10 || stage_out !== 3'd0) begin bad++; $display("FAIL mode_both got=%b/%0d want=10/0", mode_out, stage_out); end
   endtask

   task automatic test_write_entry();
      pressStep();
      total++; if (stage_out !== 3'd1 || page_out !== 4'd0) begin bad++; $display("FAIL wr_addr0 got=%0d/%0d want=1/0", stage_out, page_out); end
      pressSw(4'b0001, 17);
      pressSw(4'b1000, 2);
      total++; if (disp_data !== 16'h2001) begin bad++; $display("FAIL wr_page0 got=%h want=2001", disp_data); end
      pressStep();
      total++; if (page_out !== 4'd1) begin bad++; $display("FAIL wr_page1 got=%0d want=1", page_out); end
      pressSw(4'b0100, 3);
      total++; if (disp_data !== 16'h0100) begin bad++; $display("FAIL wr_bit24 got=%h want=0100", disp_data); end
      pressStep();
      total++; if (stage_out !== 3'd2 || page_out !== 4'd0) begin bad++; $display("FAIL wr_data got=%0d/%0d want=2/0", stage_out, page_out); end
      pressSw(4'b0010, 1);
      total++; if (disp_data !== 16'h0010) begin bad++; $display("FAIL wr_datadisp got=%h want=0010", disp_data); end
      pressStep();
      total++; if (stage_out !== 3'd3 || mem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wr_issue got=%0d/%b/%b want=3/1/1", stage_out, mem_req, busy); end
      total++; if (mem_addr !== 25'h1002001 || mem_wdata !== 16'h0010) begin bad++; $display("FAIL wr_payload got=%h/%h want=1002001/0010", mem_addr, mem_wdata); end
      total++; if (mem_op !== 2'b10 || disp_data !== 16'h2001) begin bad++; $display("FAIL wr_op got=%b/%h want=10/2001", mem_op, disp_data); end
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'b0; tick(1);
         total++; if (mem_req !== 1'b1 || stage_out !== 3'd3 || mem_addr !== 25'h1002001 || mem_wdata !== 16'h0010 || mem_op !== 2'b10) begin bad++; $display("FAIL hs_hold%0d got=%b/%0d/%h/%h want=1/3/1002001/0010", i, mem_req, stage_out, mem_addr, mem_wdata); end
      end
      mem_ready = 1'b1; tick(1); mem_ready = 1'b0;
      total++; if (stage_out !== 3'd4 || mem_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL hs_wait got=%0d/%b/%b want=4/0/1", stage_out, mem_req, busy); end
      mem_done = 1'b1; tick(1); mem_done = 1'b0;
      total++; if (op_done !== 1'b1 || stage_out !== 3'd0 || mode_out !== 2'b10) begin bad++; $display("FAIL hs_done got=%b/%0d/%b want=1/0/10", op_done, stage_out, mode_out); end
      tick(1);
      total++; if (op_done !== 1'b0) begin bad++; $display("FAIL hs_pulse got=%b want=0", op_done); end
      mem_ready = 1'b1; mem_done = 1'b1; tick(1);
      mem_ready = 1'b0; mem_done = 1'b0; tick(1);
      total++; if (stage_out !== 3'd0 || op_done !== 1'b0) begin bad++; $display("FAIL hs_idle got=%0d/%b want=0/0", stage_out, op_done); end
   endtask

   task automatic test_read();
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      pressMode(); pressMode();
      total++; if (mode_out !== 2'b01) begin bad++; $display("FAIL rd_mode got=%b want=01", mode_out); end
      pressStep();
      pressSw(4'b0011, 2);
      pressSw(4'b0001, 1);
      pressSw(4'b0100, 1);
      total++; if (disp_data !== 16'h0123) begin bad++; $display("FAIL rd_addr got=%h want=0123", disp_data); end
      pressStep(); pressStep();
      total++; if (stage_out !== 3'd3 || mem_op !== 2'b01 || mem_addr !== 25'h123) begin bad++; $display("FAIL rd_issue got=%0d/%b/%h want=3/01/123", stage_out, mem_op, mem_addr); end
      mem_ready = 1'b1; tick(1); mem_ready = 1'b0;
      mem_rdata = 16'hBEEF; mem_done = 1'b1; tick(1);
      mem_done = 1'b0; mem_rdata = 16'h0000;
      total++; if (op_done !== 1'b1 || stage_out !== 3'd5 || page_out !== 4'd0) begin bad++; $display("FAIL rd_show got=%b/%0d/%0d want=1/5/0", op_done, stage_out, page_out); end
      tick(1);
      total++; if (disp_data !== 16'hBEEF) begin bad++; $display("FAIL rd_disp got=%h want=beef", disp_data); end
      pressStep();
      total++; if (stage_out !== 3'd0 || disp_data !== 16'h0000) begin bad++; $display("FAIL rd_back got=%0d/%h want=0/0000", stage_out, disp_data); end
   endtask

   task automatic test_abort_reset();
      pressSw(4'b0001, 1);
      total++; if (mem_addr !== 25'h123) begin bad++; $display("FAIL ab_selsw got=%h want=123", mem_addr); end
      pressStep(); pressStep();
      total++; if (stage_out !== 3'd1 || page_out !== 4'd1) begin bad++; $display("FAIL ab_page1 got=%0d/%0d want=1/1", stage_out, page_out); end
      pressMode();
      total++; if (stage_out !== 3'd0 || page_out !== 4'd0 || mode_out !== 2'b01 || mem_addr !== 25'h123) begin bad++; $display("FAIL ab_sel got=%0d/%0d/%b/%h want=0/0/01/123", stage_out, page_out, mode_out, mem_addr); end
      pressStep(); pressStep(); pressStep();
      mem_ready = 1'b1; tick(1); mem_ready = 1'b0;
      total++; if (stage_out !== 3'd4) begin bad++; $display("FAIL ab_wait got=%0d want=4", stage_out); end
      #2 rst_n = 1'b0; #1;
      total++; if (mem_req !== 1'b0 || busy !== 1'b0 || stage_out !== 3'd0 || mode_out !== 2'b00) begin bad++; $display("FAIL ab_rst got=%b/%b/%0d/%b want=0/0/0/00", mem_req, busy, stage_out, mode_out); end
      total++; if (mem_addr !== 25'd0 || disp_data !== 16'd0 || page_out !== 4'd0) begin bad++; $display("FAIL ab_rstpay got=%h/%h/%0d want=0/0/0", mem_addr, disp_data, page_out); end
      tick(1); rst_n = 1'b1; tick(1);
      mem_done = 1'b1; tick(1); mem_done = 1'b0;
      total++; if (op_done !== 1'b0 || stage_out !== 3'd0) begin bad++; $display("FAIL ab_late got=%b/%0d want=0/0", op_done, stage_out); end
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_write_entry();
      test_handshake();
      test_read();
      test_abort_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
